// File: rtl/pixel_pack_24to128_if.sv
`timescale 1ns/1ps
// Bundle of the CMOS pixel input, packed-word output stream and sticky status flags.
// The slave modport is the packer; the master modport is the camera/sink side.
interface pixel_pack_24to128_if;
  logic         cmos_vsync;
  logic         cmos_href;
  logic         cmos_clken;
  logic [23:0]  cmos_data;
  logic [127:0] m_data;
  logic         m_valid;
  logic         m_ready;
  logic         m_sof;
  logic         m_eol;
  logic         overflow;
  logic         misalign;

  modport slave (
    input  cmos_vsync, cmos_href, cmos_clken, cmos_data, m_ready,
    output m_data, m_valid, m_sof, m_eol, overflow, misalign
  );

  modport master (
    output cmos_vsync, cmos_href, cmos_clken, cmos_data, m_ready,
    input  m_data, m_valid, m_sof, m_eol, overflow, misalign
  );
endinterface

// File: rtl/pixel_pack_24to128.sv
`timescale 1ns/1ps
// Packs 24-bit CMOS pixels into a little-endian byte stream of 128-bit words,
// tags first-of-frame / last-of-line, and buffers words in a first-word-fall-through FIFO.
module pixel_pack_24to128 #(
  parameter int IMG_HDISP  = 1920,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                 cmos_clk,
  input  logic                 cmos_rst,
  pixel_pack_24to128_if.slave  bus
);
  localparam int PIX_W = $clog2(IMG_HDISP);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = AW + 1;
  localparam int EW    = 130;

  logic             r_vsync_d;
  logic [119:0]     r_acc;
  logic [3:0]       r_cnt;
  logic [PIX_W-1:0] r_pix;
  logic             r_sof_pend;
  logic             r_overflow;
  logic             r_misalign;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_valid;

  logic             w_vs_rise;
  logic             w_pix_ok;
  logic [3:0]       w_cnt_base;
  logic [119:0]     w_acc_base;
  logic [PIX_W-1:0] w_pix_base;
  logic [143:0]     w_merged;
  logic [4:0]       w_sum;
  logic             w_word_done;
  logic             w_last_pix;
  logic             w_full;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic [CW-1:0]    w_count_next;
  logic [EW-1:0]    w_wr_word;
  logic [EW-1:0]    w_head;
  logic [EW-1:0]    w_entry [FIFO_DEPTH];

  // A vsync edge restarts packing in the same cycle, so the pixel seen with it is pixel 0.
  assign w_vs_rise  = bus.cmos_vsync & ~r_vsync_d;
  assign w_pix_ok   = bus.cmos_href & bus.cmos_clken;
  assign w_cnt_base = w_vs_rise ? 4'd0 : r_cnt;
  assign w_acc_base = w_vs_rise ? 120'd0 : r_acc;
  assign w_pix_base = w_vs_rise ? '0 : r_pix;

  // Bytes above r_cnt in the accumulator are always zero, so OR-merging is safe.
  assign w_merged    = {24'd0, w_acc_base} | ({120'd0, bus.cmos_data} << {w_cnt_base, 3'b000});
  assign w_sum       = {1'b0, w_cnt_base} + 5'd3;
  assign w_word_done = w_pix_ok & w_sum[4];
  assign w_last_pix  = (w_pix_base == PIX_W'(IMG_HDISP - 1));

  assign w_full       = (r_count == CW'(FIFO_DEPTH));
  assign w_pop        = r_valid & bus.m_ready;
  assign w_push       = w_word_done & (~w_full | w_pop);
  assign w_drop       = w_word_done & w_full & ~w_pop;
  assign w_count_next = r_count + CW'(w_push) - CW'(w_pop);
  assign w_wr_word    = {w_last_pix, r_sof_pend, w_merged[127:0]};

  generate
    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
      logic [EW-1:0] r_word;
      always_ff @(posedge cmos_clk) begin
        if (cmos_rst) begin
          r_word <= '0;
        end else if (w_push && (r_wr_ptr == AW'(gi))) begin
          r_word <= w_wr_word;
        end
      end
      assign w_entry[gi] = r_word;
    end
  endgenerate

  assign w_head       = w_entry[r_rd_ptr];
  assign bus.m_data   = w_head[127:0];
  assign bus.m_sof    = w_head[128];
  assign bus.m_eol    = w_head[129];
  assign bus.m_valid  = r_valid;
  assign bus.overflow = r_overflow;
  assign bus.misalign = r_misalign;

  always_ff @(posedge cmos_clk) begin
    if (cmos_rst) begin
      r_vsync_d  <= 1'b1;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_pix      <= '0;
      r_sof_pend <= 1'b0;
      r_overflow <= 1'b0;
      r_misalign <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_valid    <= 1'b0;
    end else begin
      r_vsync_d <= bus.cmos_vsync;

      if (w_vs_rise) begin
        r_misalign <= (r_cnt != 4'd0);
      end

      if (w_vs_rise) begin
        r_overflow <= 1'b0;
      end else if (w_drop) begin
        r_overflow <= 1'b1;
      end

      if (w_vs_rise) begin
        r_sof_pend <= 1'b1;
      end else if (w_word_done) begin
        r_sof_pend <= 1'b0;
      end

      // Packing advances even when the finished word is dropped.
      if (w_pix_ok) begin
        r_cnt <= w_sum[3:0];
        r_pix <= w_last_pix ? '0 : w_pix_base + PIX_W'(1);
        if (w_word_done) begin
          r_acc <= {104'd0, w_merged[143:128]};
        end else begin
          r_acc <= w_merged[119:0];
        end
      end else if (w_vs_rise) begin
        r_acc <= '0;
        r_cnt <= '0;
        r_pix <= '0;
      end

      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count <= w_count_next;
      r_valid <= (w_count_next != '0);
    end
  end
endmodule
